dm_sba_ctrl: RTL
================

// Module: dm_sba_ctrl
// PURPOSE
//  Debug-module System Bus Access (SBA) controller: owns sbcs/sbaddress0/sbdata0, decodes DMI accesses to them
//  and sequences single 32-bit transactions on the core data bus on behalf of the debugger. Sits between the
//  DMI register decoder of the debug module and the bus arbiter's debug master port.
// PARAMETERS
//  TIMEOUT  256  bus cycles waiting for ack/err before abort with sberror=1 (0 = no timeout)
// PORTS
//  clk         in   1   clock
//  rst         in   1   asynchronous reset, active-high
//  dmactive    in   1   dmcontrol.dmactive; 0 = hold all SBA state at reset values
//  dmi_req     in   1   DMI access strobe (one cycle per access)
//  dmi_we      in   1   1 = write, 0 = read
//  dmi_addr    in   7   DM register address (0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0; others ignored)
//  dmi_wdata   in   32  DMI write data
//  dmi_rvalid  out  1   read data valid, exactly 1 cycle after a dmi_req read hitting 0x38/0x39/0x3C
//  dmi_rdata   out  32  registered read data
//  bus_req     out  1   bus request, held until bus_ack or bus_err
//  bus_we      out  1   1 = write
//  bus_addr    out  32  word address (bits[1:0] always 0)
//  bus_wdata   out  32  write data
//  bus_rdata   in   32  read data, sampled on bus_ack
//  bus_ack     in   1   transaction done
//  bus_err     in   1   transaction error (takes priority over bus_ack in the same cycle)
// BEHAVIOUR
//  Reset (rst, or dmactive=0 sampled high on clk): all outputs 0; sbaddress0=sbdata0=0; state IDLE;
//   sbcs = {sbversion=1, sbaccess=2, sbasize=32, sbaccess32=1, all other fields 0}.
//  sbcs RO fields: sbversion=1, sbasize=32, sbaccess32=1, other sbaccessN=0, sbbusy=(state!=IDLE).
//   RW fields: sbreadonaddr, sbaccess, sbautoincrement, sbreadondata. W1C fields: sbbusyerror, sberror.
//  FSM IDLE -> BUS: start decided on cycle N (DMI access); bus_req=1 from cycle N+1, addr/we/wdata stable.
//   BUS -> IDLE on ack (read: sbdata0<=bus_rdata), on err (sberror=2), or on TIMEOUT expiry (sberror=1);
//   sbbusy clears the cycle after completion. On success with sbautoincrement: sbaddress0 += 4 (wraps at 2^32).
//  Start conditions (only when IDLE, sberror==0 and sbbusyerror==0):
//   write sbaddress0 & sbreadonaddr -> read at new address; write sbdata0 -> write of new data to sbaddress0;
//   read sbdata0 & sbreadondata -> read started after returning the current sbdata0.
//  Pre-checks at start: sbaccess!=2 -> sberror=4, no bus cycle; sbaddress0[1:0]!=0 -> sberror=3, no bus cycle.
//  While busy: DMI write to sbaddress0/sbdata0 or read of sbdata0 -> sbbusyerror=1, write ignored,
//   read returns stale sbdata0, no new access. sbcs writes while busy update RW fields only for next access.
//  While sbbusyerror or sberror nonzero: register writes still land, but no access starts.
//  Simultaneous W1C clear and new error in same cycle: new error wins.
//  dmactive drop while BUS: bus_req stays high until ack/err/timeout (no mid-transaction abort), result
//   discarded, then reset values apply.
//  Reads of unmapped DM addresses: no dmi_rvalid (other DM blocks own them).
// STRUCTURE
//  Shared package additions: sb_state_t enum {SB_IDLE, SB_BUS}; localparams DM_SBCS=7'h38,
//   DM_SBADDRESS0=7'h39, DM_SBDATA0=7'h3C; sberror codes SBERR_NONE=0, SBERR_TIMEOUT=1, SBERR_BADADDR=2,
//   SBERR_ALIGN=3, SBERR_SIZE=4; sbcs register stored as the packed sbcs_t.
//  Single module, no sub-module; timeout counter is $clog2(TIMEOUT+1) bits, cleared on each bus start.
// TESTING
//  1 sbcs=readonaddr|autoinc|access=2; write sbaddress0=0x1000; bus ack rdata=0xDEADBEEF after 3 cycles ->
//    sbdata0=0xDEADBEEF, sbaddress0=0x1004, sbbusy 1 then 0.
//  2 write sbaddress0=0x2000 (readonaddr=0), write sbdata0=0x12345678 -> one bus write addr 0x2000,
//    wdata 0x12345678, bus_req held until ack.
//  3 write sbdata0 while sbbusy=1 -> sbbusyerror=1, no second bus_req; next write ignored until sbbusyerror
//    W1C'd, then access proceeds.
//  4 sbaccess=0 then write sbdata0 -> sberror=4, bus_req never asserts; sbaddress0=0x1002 -> sberror=3.
//  5 bus_err on read -> sberror=2, sbdata0 unchanged; no ack for TIMEOUT cycles -> sberror=1, bus_req drops.
//  6 readondata+autoinc: read sbdata0 x3 over 0x3000.. -> returns prior values, reads at 0x3000/4/8;
//    dmactive=0 mid-access -> bus_req held to ack, then all registers at reset values.

Source files
------------

// File: rtl/dm_sba_ctrl_pkg.sv
// Shared debug-module definitions for the System Bus Access block:
// FSM states, DM register addresses, sberror codes and the sbcs layout.
package dm_sba_ctrl_pkg;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUS  = 1'b1
  } sb_state_t;

  localparam logic [6:0] DM_SBCS       = 7'h38;
  localparam logic [6:0] DM_SBADDRESS0 = 7'h39;
  localparam logic [6:0] DM_SBDATA0    = 7'h3C;

  localparam logic [2:0] SBERR_NONE    = 3'd0;
  localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
  localparam logic [2:0] SBERR_BADADDR = 3'd2;
  localparam logic [2:0] SBERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBERR_SIZE    = 3'd4;

  // Only 32-bit accesses are implemented.
  localparam logic [2:0] SBACCESS_32   = 3'd2;

  typedef struct packed {
    logic [2:0] sbversion;
    logic [5:0] reserved;
    logic       sbbusyerror;
    logic       sbbusy;
    logic       sbreadonaddr;
    logic [2:0] sbaccess;
    logic       sbautoincrement;
    logic       sbreadondata;
    logic [2:0] sberror;
    logic [6:0] sbasize;
    logic       sbaccess128;
    logic       sbaccess64;
    logic       sbaccess32;
    logic       sbaccess16;
    logic       sbaccess8;
  } sbcs_t;

  // sbversion=1, sbaccess=2, sbasize=32, sbaccess32=1, everything else 0.
  localparam sbcs_t SBCS_RESET = sbcs_t'(32'h2004_0404);

endpackage

// File: rtl/dm_sba_ctrl.sv
// System Bus Access controller: owns sbcs/sbaddress0/sbdata0, decodes DMI
// accesses to them and runs single 32-bit bus transactions for the debugger.
module dm_sba_ctrl
  import dm_sba_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmactive,
  input  logic        dmi_req,
  input  logic        dmi_we,
  input  logic [6:0]  dmi_addr,
  input  logic [31:0] dmi_wdata,
  output logic        dmi_rvalid,
  output logic [31:0] dmi_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  sb_state_t   state, state_d;
  sbcs_t       sbcs_q, sbcs_d, sbcs_rd;
  logic [31:0] sbaddress0_q, sbaddress0_d;
  logic [31:0] sbdata0_q, sbdata0_d;
  logic [TW-1:0] tmo_cnt;
  logic        cur_autoinc;

  logic        is_busy;
  logic        wr_sbcs, wr_addr, wr_data, rd_sbcs, rd_addr, rd_data;
  logic        errs_clear, busy_hit, want_start, bus_go, start_we;
  logic [31:0] start_addr;
  logic [2:0]  start_err;
  logic        done_ok, done_err, tmo_hit;
  logic        rvalid_d;
  logic [31:0] rdata_d;

  assign bus_req = is_busy;

  // Decode the DMI access, choose the next FSM state and compute register updates.
  always_comb begin
    is_busy    = (state == SB_BUS);

    wr_sbcs    = dmactive && dmi_req &&  dmi_we && (dmi_addr == DM_SBCS);
    wr_addr    = dmactive && dmi_req &&  dmi_we && (dmi_addr == DM_SBADDRESS0);
    wr_data    = dmactive && dmi_req &&  dmi_we && (dmi_addr == DM_SBDATA0);
    rd_sbcs    = dmactive && dmi_req && !dmi_we && (dmi_addr == DM_SBCS);
    rd_addr    = dmactive && dmi_req && !dmi_we && (dmi_addr == DM_SBADDRESS0);
    rd_data    = dmactive && dmi_req && !dmi_we && (dmi_addr == DM_SBDATA0);

    errs_clear = (sbcs_q.sberror == SBERR_NONE) && !sbcs_q.sbbusyerror;
    busy_hit   = is_busy && (wr_addr || wr_data || rd_data);
    want_start = !is_busy && errs_clear &&
                 ((wr_addr && sbcs_q.sbreadonaddr) || wr_data ||
                  (rd_data && sbcs_q.sbreadondata));

    // Read-on-address uses the address being written, not the stored one.
    start_addr = wr_addr ? dmi_wdata : sbaddress0_q;
    start_we   = wr_data;
    if (sbcs_q.sbaccess != SBACCESS_32)
      start_err = SBERR_SIZE;
    else if (start_addr[1:0] != 2'b00)
      start_err = SBERR_ALIGN;
    else
      start_err = SBERR_NONE;
    bus_go     = want_start && (start_err == SBERR_NONE);

    done_err   = is_busy && bus_err;
    done_ok    = is_busy && bus_ack && !bus_err;
    tmo_hit    = is_busy && (TIMEOUT != 0) && (tmo_cnt == TMO_LAST) &&
                 !bus_ack && !bus_err;

    state_d = state;
    case (state)
      SB_IDLE: if (bus_go) state_d = SB_BUS;
      SB_BUS:  if (done_ok || done_err || tmo_hit) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase

    sbcs_d       = sbcs_q;
    sbaddress0_d = sbaddress0_q;
    sbdata0_d    = sbdata0_q;

    if (wr_sbcs) begin
      sbcs_d.sbreadonaddr    = dmi_wdata[20];
      sbcs_d.sbaccess        = dmi_wdata[19:17];
      sbcs_d.sbautoincrement = dmi_wdata[16];
      sbcs_d.sbreadondata    = dmi_wdata[15];
      if (dmi_wdata[22]) sbcs_d.sbbusyerror = 1'b0;
      sbcs_d.sberror = sbcs_q.sberror & ~dmi_wdata[14:12];
    end
    if (wr_addr && !is_busy) sbaddress0_d = dmi_wdata;
    if (wr_data && !is_busy) sbdata0_d    = dmi_wdata;

    // New errors are applied after the W1C so they win in the same cycle.
    if (busy_hit) sbcs_d.sbbusyerror = 1'b1;
    if (want_start && (start_err != SBERR_NONE)) sbcs_d.sberror = start_err;
    if (done_ok) begin
      if (!bus_we)     sbdata0_d    = bus_rdata;
      if (cur_autoinc) sbaddress0_d = sbaddress0_q + 32'd4;
    end
    if (done_err) sbcs_d.sberror = SBERR_BADADDR;
    if (tmo_hit)  sbcs_d.sberror = SBERR_TIMEOUT;

    // With the DM inactive everything debugger-visible sits at reset values;
    // an in-flight transaction still completes but its result is dropped.
    if (!dmactive) begin
      sbcs_d       = SBCS_RESET;
      sbaddress0_d = '0;
      sbdata0_d    = '0;
    end

    sbcs_rd        = sbcs_q;
    sbcs_rd.sbbusy = is_busy;
    rvalid_d       = rd_sbcs || rd_addr || rd_data;
    rdata_d        = '0;
    if (rd_sbcs) rdata_d = sbcs_rd;
    if (rd_addr) rdata_d = sbaddress0_q;
    if (rd_data) rdata_d = sbdata0_q;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SB_IDLE;
    else     state <= state_d;
  end

  // Architectural registers and the registered DMI read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbcs_q       <= SBCS_RESET;
      sbaddress0_q <= '0;
      sbdata0_q    <= '0;
      dmi_rvalid   <= 1'b0;
      dmi_rdata    <= '0;
    end else begin
      sbcs_q       <= sbcs_d;
      sbaddress0_q <= sbaddress0_d;
      sbdata0_q    <= sbdata0_d;
      dmi_rvalid   <= rvalid_d;
      dmi_rdata    <= rdata_d;
    end
  end

  // Bus-side transaction registers: captured at start, held through BUS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cur_autoinc <= 1'b0;
      tmo_cnt     <= '0;
    end else if (bus_go) begin
      bus_we      <= start_we;
      bus_addr    <= start_addr;
      bus_wdata   <= start_we ? dmi_wdata : 32'h0;
      cur_autoinc <= sbcs_q.sbautoincrement;
      tmo_cnt     <= '0;
    end else if (is_busy) begin
      tmo_cnt     <= tmo_cnt + TW'(1);
    end else if (!dmactive) begin
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cur_autoinc <= 1'b0;
      tmo_cnt     <= '0;
    end
  end

endmodule
